game_ctrl: RTL and testbench

- Game-level sequencer for the ping-pong datapath (wall/bar/ball position block).
- Runs title → serve → play → miss → game-over flow, gates the per-frame position-update pulse, and restarts the ball on each serve.
- Keeps the BCD score and remaining lives for the text/score overlay.
- Sits between the VGA sync (frame tick) and the object datapath; consumes its hit/miss status.

---
 rtl/game_pkg.sv | 30 +++
 rtl/game_ctrl_if.sv | 27 ++
 rtl/game_tone_gen.sv | 78 +++++++
 rtl/game_ctrl.sv | 140 ++++++++++++++
 tb/tb_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared state encoding, widths and the BCD helper for the ping-pong game sequencer.
package game_pkg;

   localparam int TIMER_W = 8;
   localparam int BCD_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_LOST  = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   // Two-digit BCD increment; 99 wraps back to 00.
   function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] v);
      logic [BCD_W-1:0] units;
      logic [BCD_W-1:0] tens;
      units = v[BCD_W-1:0];
      tens  = v[2*BCD_W-1:BCD_W];
      if (units == BCD_W'(9)) begin
         units = '0;
         tens  = (tens == BCD_W'(9)) ? '0 : tens + BCD_W'(1);
      end else begin
         units = units + BCD_W'(1);
      end
      return {tens, units};
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Frame/status inputs and score/control outputs between the VGA sync, datapath and game sequencer.
interface game_ctrl_if;
   import game_pkg::*;

   logic               frame_tick;
   logic               start_btn;
   logic               hit;
   logic               miss;
   logic               obj_rst;
   logic               update_en;
   logic [2*BCD_W-1:0] score_bcd;
   logic [2:0]         lives;
   logic [2:0]         state_code;
   logic               game_over;
   logic               snd_tone;

   modport master (
      output frame_tick, start_btn, hit, miss,
      input  obj_rst, update_en, score_bcd, lives, state_code, game_over, snd_tone
   );

   modport slave (
      input  frame_tick, start_btn, hit, miss,
      output obj_rst, update_en, score_bcd, lives, state_code, game_over, snd_tone
   );

endinterface

// File: rtl/game_tone_gen.sv
// Square-wave tone for counted hits and misses, lasting SND_FRAMES frames; a miss tone preempts a hit tone.
module game_tone_gen #(
   parameter int HIT_DIV    = 50000,
   parameter int MISS_DIV   = 100000,
   parameter int SND_FRAMES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic hit_evt,
   input  logic miss_evt,
   output logic snd_tone
);
   import game_pkg::*;

   localparam int MAX_DIV = (HIT_DIV > MISS_DIV) ? HIT_DIV : MISS_DIV;
   localparam int DIV_W   = $clog2(MAX_DIV + 1);

   logic               active_q, active_d;
   logic               is_miss_q, is_miss_d;
   logic               tone_q, tone_d;
   logic [DIV_W-1:0]   div_q, div_d, div_last;
   logic [TIMER_W-1:0] frames_q, frames_d;

   assign div_last = is_miss_q ? DIV_W'(MISS_DIV - 1) : DIV_W'(HIT_DIV - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q  <= 1'b0;
         is_miss_q <= 1'b0;
         tone_q    <= 1'b0;
         div_q     <= '0;
         frames_q  <= '0;
      end else begin
         active_q  <= active_d;
         is_miss_q <= is_miss_d;
         tone_q    <= tone_d;
         div_q     <= div_d;
         frames_q  <= frames_d;
      end
   end

   // A new event restarts the divider from a low phase; hits cannot interrupt a miss tone.
   always_comb begin
      active_d  = active_q;
      is_miss_d = is_miss_q;
      tone_d    = tone_q;
      div_d     = div_q;
      frames_d  = frames_q;
      if (miss_evt || (hit_evt && !(active_q && is_miss_q))) begin
         active_d  = 1'b1;
         is_miss_d = miss_evt;
         tone_d    = 1'b0;
         div_d     = '0;
         frames_d  = '0;
      end else if (active_q) begin
         if (frame_tick && (frames_q == TIMER_W'(SND_FRAMES - 1))) begin
            active_d = 1'b0;
            tone_d   = 1'b0;
            div_d    = '0;
            frames_d = '0;
         end else begin
            if (frame_tick) begin
               frames_d = frames_q + TIMER_W'(1);
            end
            if (div_q == div_last) begin
               div_d  = '0;
               tone_d = ~tone_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
      end
   end

   assign snd_tone = tone_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: idle/serve/play/lost/over flow, BCD score, lives and datapath update gating.
// Define GAME_SOUND_EN to build the hit/miss tone generator; otherwise snd_tone is tied low.
module game_ctrl
   import game_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 90
`ifdef GAME_SOUND_EN
   ,
   parameter int HIT_DIV      = 50000,
   parameter int MISS_DIV     = 100000,
   parameter int SND_FRAMES   = 8
`endif
) (
   input logic        clk,
   input logic        rst,
   game_ctrl_if.slave bus
);

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2*BCD_W-1:0] score_q, score_d;
   logic [2:0]         lives_q, lives_d;
   logic               start_q, start_d;
   logic               hit_armed_q, hit_armed_d;
   logic               miss_armed_q, miss_armed_d;
   logic               start_evt, hit_seen, hit_evt, miss_evt;

   assign start_evt = bus.start_btn & ~start_q;
   assign miss_evt  = (state_q == ST_PLAY) & miss_armed_q & bus.miss;
   assign hit_seen  = (state_q == ST_PLAY) & hit_armed_q & bus.hit;
   assign hit_evt   = hit_seen & ~miss_evt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         score_q      <= '0;
         lives_q      <= 3'(LIVES);
         start_q      <= 1'b0;
         hit_armed_q  <= 1'b0;
         miss_armed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         start_q      <= start_d;
         hit_armed_q  <= hit_armed_d;
         miss_armed_q <= miss_armed_d;
      end
   end

   // The frame timer is cleared on every exit, so a tick on a transition only counts for the old state.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_evt) state_d = ST_SERVE;
         end
         ST_SERVE: begin
            if (bus.frame_tick) begin
               if (timer_q == TIMER_W'(SERVE_FRAMES - 1)) begin
                  state_d = ST_PLAY;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
         end
         ST_PLAY: begin
            if (miss_evt) state_d = ST_LOST;
         end
         ST_LOST: begin
            if (bus.frame_tick) begin
               if (timer_q == TIMER_W'(MISS_FRAMES - 1)) begin
                  state_d = (lives_q == 3'd0) ? ST_OVER : ST_SERVE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TIMER_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // A hit discarded by a simultaneous miss still uses up this frame's hit arm.
   always_comb begin
      start_d      = bus.start_btn;
      score_d      = score_q;
      lives_d      = lives_q;
      hit_armed_d  = bus.frame_tick | (hit_armed_q & ~hit_seen);
      miss_armed_d = bus.frame_tick | (miss_armed_q & ~miss_evt);
      if (((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_evt) begin
         score_d = '0;
         lives_d = 3'(LIVES);
      end else if (miss_evt) begin
         lives_d = lives_q - 3'd1;
      end else if (hit_evt) begin
         score_d = bcd_inc(score_q);
      end
   end

   always_comb begin
      bus.obj_rst    = (state_d == ST_SERVE) && (state_q != ST_SERVE);
      bus.update_en  = bus.frame_tick && (state_q == ST_PLAY);
      bus.game_over  = (state_q == ST_OVER);
      bus.state_code = state_q;
      bus.score_bcd  = score_q;
      bus.lives      = lives_q;
   end

`ifdef GAME_SOUND_EN
   logic snd_tone;

   game_tone_gen #(
      .HIT_DIV    (HIT_DIV),
      .MISS_DIV   (MISS_DIV),
      .SND_FRAMES (SND_FRAMES)
   ) u_tone (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (bus.frame_tick),
      .hit_evt    (hit_evt),
      .miss_evt   (miss_evt),
      .snd_tone   (snd_tone)
   );

   assign bus.snd_tone = snd_tone;
`else
   assign bus.snd_tone = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: frame-level directed stimulus with a queued expectation scoreboard.
// With GAME_SOUND_EN defined it also checks the hit/miss tone waveform.
module tb_game_ctrl;

   localparam int FP           = 10;
   localparam int LIVES        = 3;
   localparam int SERVE_FRAMES = 60;
   localparam int MISS_FRAMES  = 90;
`ifdef GAME_SOUND_EN
   localparam int HIT_DIV      = 4;
   localparam int MISS_DIV     = 6;
   localparam int SND_FRAMES   = 8;
`endif

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [7:0] score;
      logic [2:0] lives;
      logic       go;
      logic       objRst;
      logic       updEn;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic rstLvl;
   logic startLvl;
   int   checks   = 0;
   int   failures = 0;
   int   expScore;
   int   expLives;
   exp_t expQ[$];

   always #5 clk = ~clk;

   game_ctrl_if bus();

   game_ctrl #(
      .LIVES        (LIVES),
      .SERVE_FRAMES (SERVE_FRAMES),
      .MISS_FRAMES  (MISS_FRAMES)
`ifdef GAME_SOUND_EN
      ,
      .HIT_DIV      (HIT_DIV),
      .MISS_DIV     (MISS_DIV),
      .SND_FRAMES   (SND_FRAMES)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] toBcd(input int s);
      return 8'(((s / 10) % 10) * 16 + (s % 10));
   endfunction

   task automatic applyStimulus(input logic ft, input logic h, input logic m);
      @(posedge clk);
      #1;
      rst            = rstLvl;
      bus.start_btn  = startLvl;
      bus.frame_tick = ft;
      bus.hit        = h;
      bus.miss       = m;
   endtask

   task automatic expectNow(input string tag, input int st, input logic objRst, input logic updEn);
      exp_t e;
      e.tag    = tag;
      e.st     = 3'(st);
      e.score  = toBcd(expScore);
      e.lives  = 3'(expLives);
      e.go     = (st == 4);
      e.objRst = objRst;
      e.updEn  = updEn;
      expQ.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({e.tag, ".state"}, 32'(bus.state_code), 32'(e.st));
         checkOutput({e.tag, ".score"}, 32'(bus.score_bcd), 32'(e.score));
         checkOutput({e.tag, ".lives"}, 32'(bus.lives), 32'(e.lives));
         checkOutput({e.tag, ".gameOver"}, 32'(bus.game_over), 32'(e.go));
         checkOutput({e.tag, ".objRst"}, 32'(bus.obj_rst), 32'(e.objRst));
         checkOutput({e.tag, ".updateEn"}, 32'(bus.update_en), 32'(e.updEn));
      end
   end

   // Enters at the first SERVE cycle; a start press mid-serve must not disturb the count.
   task automatic serveToPlay(input string tag);
      repeat (FP - 2) applyStimulus(0, 0, 0);
      for (int f = 0; f < SERVE_FRAMES - 1; f++) begin
         startLvl = (f >= 5 && f < 10);
         applyStimulus(1, 0, 0);
         repeat (FP - 1) applyStimulus(0, 0, 0);
      end
      applyStimulus(1, 0, 0);
      expectNow({tag, ".lastTick"}, 1, 0, 0);
      applyStimulus(0, 0, 0);
      expectNow({tag, ".play"}, 2, 0, 0);
      repeat (FP - 2) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      expectNow({tag, ".upd"}, 2, 0, 1);
   endtask

   // Each frame: one armed hit, then the next tick; ends on a tick cycle.
   task automatic hitFrames(input int n, input string tag);
      repeat (n) begin
         applyStimulus(0, 1, 0);
         expScore = (expScore + 1) % 100;
         repeat (FP - 2) applyStimulus(0, 0, 0);
         applyStimulus(1, 0, 0);
      end
      expectNow(tag, 2, 0, 1);
   endtask

   // Enters right after a PLAY tick; hit/miss pulses inside LOST must be ignored.
   task automatic missAndLose(input logic withHit, input string tag);
      applyStimulus(0, withHit, 1);
      expectNow({tag, ".missCyc"}, 2, 0, 0);
      expLives--;
      applyStimulus(0, 0, 0);
      expectNow({tag, ".lost"}, 3, 0, 0);
      repeat (FP - 3) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1);
      repeat (FP - 2) applyStimulus(0, 0, 0);
      repeat (MISS_FRAMES - 2) begin
         applyStimulus(1, 0, 0);
         repeat (FP - 1) applyStimulus(0, 0, 0);
      end
      applyStimulus(1, 0, 0);
      expectNow({tag, ".lastTick"}, 3, expLives != 0, 0);
      applyStimulus(0, 0, 0);
      expectNow({tag, ".next"}, (expLives != 0) ? 1 : 4, 0, 0);
   endtask

`ifdef GAME_SOUND_EN
   // Hit at k=0 starts a HIT_DIV tone; the miss at k=31 preempts it with a MISS_DIV tone.
   function automatic logic expTone(input int k);
      if (k <= 31) return 1'(((k - 1) / HIT_DIV) % 2);
      if (k < 110) return 1'(((k - 32) / MISS_DIV) % 2);
      return 1'b0;
   endfunction
`endif

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic ft, h, m;
      rstLvl         = 1'b1;
      startLvl       = 1'b0;
      rst            = 1'b1;
      bus.frame_tick = 1'b0;
      bus.hit        = 1'b0;
      bus.miss       = 1'b0;
      bus.start_btn  = 1'b0;
      expScore       = 0;
      expLives       = LIVES;

      repeat (3) applyStimulus(0, 0, 0);
      rstLvl = 1'b0;
      applyStimulus(0, 0, 0);
      expectNow("reset", 0, 0, 0);
      @(negedge clk);
      checkOutput("reset.snd", 32'(bus.snd_tone), 32'd0);

      for (int f = 0; f < 10; f++) begin
         applyStimulus(1, 0, 0);
         expectNow("idle.tick", 0, 0, 0);
         applyStimulus(0, 1, 1);
         @(negedge clk);
         checkOutput("idle.snd", 32'(bus.snd_tone), 32'd0);
         repeat (FP - 2) applyStimulus(0, 0, 0);
      end

      startLvl = 1'b1;
      applyStimulus(0, 0, 0);
      expectNow("start.pulse", 0, 1, 0);
      applyStimulus(0, 0, 0);
      expectNow("start.serve", 1, 0, 0);
      serveToPlay("serve1");

      repeat (5) applyStimulus(0, 1, 0);
      expScore = 1;
      repeat (FP - 6) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      expectNow("hold5", 2, 0, 1);
      hitFrames(2, "score03");
      hitFrames(6, "score09");
      hitFrames(1, "score10");
      hitFrames(89, "score99");
      hitFrames(1, "wrap00");
      hitFrames(2, "score02");

      missAndLose(1'b1, "miss1");
      serveToPlay("serve2");
      missAndLose(1'b0, "miss2");
      serveToPlay("serve3");
      missAndLose(1'b0, "miss3");

      for (int f = 0; f < 3; f++) begin
         applyStimulus(1, 0, 0);
         applyStimulus(0, 1, 1);
         expectNow("overHold", 4, 0, 0);
         repeat (FP - 2) applyStimulus(0, 0, 0);
      end

      startLvl = 1'b1;
      applyStimulus(0, 0, 0);
      expectNow("overStart", 4, 1, 0);
      expScore = 0;
      expLives = LIVES;
      applyStimulus(0, 0, 0);
      expectNow("restart", 1, 0, 0);
      applyStimulus(0, 0, 0);
      expectNow("startHeld", 1, 0, 0);

      startLvl = 1'b0;
      applyStimulus(1, 0, 0);
      rstLvl = 1'b1;
      applyStimulus(0, 0, 0);
      expectNow("rstCyc", 1, 0, 0);
      rstLvl = 1'b0;
      applyStimulus(0, 0, 0);
      expectNow("rstIdle", 0, 0, 0);

      startLvl = 1'b1;
      applyStimulus(0, 0, 0);
      expectNow("start2.pulse", 0, 1, 0);
      applyStimulus(0, 0, 0);
      expectNow("start2.serve", 1, 0, 0);
      serveToPlay("serve4");

`ifdef GAME_SOUND_EN
      for (int k = 0; k <= 120; k++) begin
         ft = (k % FP == 9);
         h  = (k == 0) || (k == 31);
         m  = (k == 31);
         applyStimulus(ft, h, m);
         if (k == 0) expScore = 1;
         if (k == 31) expLives = LIVES - 1;
         if (k == 32) expectNow("tone.lost", 3, 0, 0);
         if (k >= 1) begin
            @(negedge clk);
            checkOutput("tone", 32'(bus.snd_tone), 32'(expTone(k)));
         end
      end
`else
      ft = 1'b0;
      h  = 1'b1;
      m  = 1'b0;
      applyStimulus(ft, h, m);
      expScore = 1;
      applyStimulus(0, 0, 0);
      expectNow("noSound.hit", 2, 0, 0);
      @(negedge clk);
      checkOutput("noSound.snd", 32'(bus.snd_tone), 32'd0);
`endif

      applyStimulus(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
